// File: rtl/ibis_video_timing.sv
// Raster timing generator: pixel/line counters advanced on enable strobes, with
// registered decode of data_enable, syncs, coordinates and line/frame strobes.
module ibis_video_timing #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit H_SYNC_POL  = 1'b0,
  parameter bit V_SYNC_POL  = 1'b0,
  parameter int COORD_WIDTH = 12
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  output logic                   data_enable,
  output logic [1:0]             control,
  output logic                   hsync,
  output logic                   vsync,
  output logic [COORD_WIDTH-1:0] x,
  output logic [COORD_WIDTH-1:0] y,
  output logic                   line_start,
  output logic                   frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
      COORD_WIDTH < 1 || COORD_WIDTH > 32) begin : g_bad_param
    $fatal(1, "ibis_video_timing: timing parameters must be >= 1");
  end
  if (longint'(H_TOTAL - 1) >= (longint'(1) << COORD_WIDTH) ||
      longint'(V_TOTAL - 1) >= (longint'(1) << COORD_WIDTH)) begin : g_bad_width
    $fatal(1, "ibis_video_timing: H_TOTAL-1 / V_TOTAL-1 do not fit in COORD_WIDTH");
  end

  // Sync windows end before the back porch, so every bound is < H_TOTAL / V_TOTAL.
  localparam logic [COORD_WIDTH-1:0] H_LAST   = COORD_WIDTH'(H_TOTAL - 1);
  localparam logic [COORD_WIDTH-1:0] V_LAST   = COORD_WIDTH'(V_TOTAL - 1);
  localparam logic [COORD_WIDTH-1:0] H_ACT    = COORD_WIDTH'(H_ACTIVE);
  localparam logic [COORD_WIDTH-1:0] V_ACT    = COORD_WIDTH'(V_ACTIVE);
  localparam logic [COORD_WIDTH-1:0] HS_BEGIN = COORD_WIDTH'(H_ACTIVE + H_FRONT);
  localparam logic [COORD_WIDTH-1:0] HS_END   = COORD_WIDTH'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [COORD_WIDTH-1:0] VS_BEGIN = COORD_WIDTH'(V_ACTIVE + V_FRONT);
  localparam logic [COORD_WIDTH-1:0] VS_END   = COORD_WIDTH'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [COORD_WIDTH-1:0] r_h;
  logic [COORD_WIDTH-1:0] r_v;
  logic                   r_de;
  logic                   r_hsync;
  logic                   r_vsync;
  logic [COORD_WIDTH-1:0] r_x;
  logic [COORD_WIDTH-1:0] r_y;
  logic                   r_line_start;
  logic                   r_frame_start;

  logic w_h_wrap;
  logic w_v_wrap;
  logic w_de;
  logic w_hs_act;
  logic w_vs_act;

  assign w_h_wrap = (r_h == H_LAST);
  assign w_v_wrap = (r_v == V_LAST);
  assign w_de     = (r_h < H_ACT) && (r_v < V_ACT);
  assign w_hs_act = (r_h >= HS_BEGIN) && (r_h < HS_END);
  assign w_vs_act = (r_v >= VS_BEGIN) && (r_v < VS_END);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_h <= '0;
      r_v <= '0;
    end else if (enable) begin
      r_h <= w_h_wrap ? '0 : r_h + COORD_WIDTH'(1);
      if (w_h_wrap) begin
        r_v <= w_v_wrap ? '0 : r_v + COORD_WIDTH'(1);
      end
    end
  end

  // Outputs capture the decode of the position before this edge's advance.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_de          <= 1'b0;
      r_hsync       <= ~H_SYNC_POL;
      r_vsync       <= ~V_SYNC_POL;
      r_x           <= '0;
      r_y           <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (enable) begin
      r_de          <= w_de;
      r_hsync       <= w_hs_act ? H_SYNC_POL : ~H_SYNC_POL;
      r_vsync       <= w_vs_act ? V_SYNC_POL : ~V_SYNC_POL;
      r_x           <= r_h;
      r_y           <= r_v;
      r_line_start  <= (r_h == '0);
      r_frame_start <= (r_h == '0) && (r_v == '0);
    end
  end

  assign data_enable = r_de;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign control     = {r_vsync, r_hsync};
  assign x           = r_x;
  assign y           = r_y;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule

// File: doc/ibis_video_timing.md
Name: ibis_video_timing

Overview:
- Raster timing generator that sits directly upstream of ibis_tmds_encoder.
- Produces the per-pixel `data_enable`, sync `control` pair, pixel coordinates and frame/line strobes that drive the encoder and the pixel source.
- Advances only on pixel-rate `enable` strobes. The encoder shares the same `clock`/`enable`, so both stay cycle-aligned.
- Line order is active, front porch, sync, back porch. This holds horizontally and vertically.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_SYNC_POL, 0, hsync asserted level (0 = active-low)
- V_SYNC_POL, 0, vsync asserted level (0 = active-low)
- COORD_WIDTH, 12, width of the x/y outputs and internal counters

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  pixel clock enable; all state holds when low
- data_enable  out  1  high during active video; feeds the encoder's `data_enable`
- control  out  2  {vsync, hsync} at line level; feeds the encoder's `control` on the sync channel
- hsync  out  1  horizontal sync at line level
- vsync  out  1  vertical sync at line level
- x  out  COORD_WIDTH  horizontal position of the current output pixel
- y  out  COORD_WIDTH  vertical position of the current output line
- line_start  out  1  one-enable pulse at x == 0
- frame_start  out  1  one-enable pulse at x == 0, y == 0

Behaviour:
- Definitions: H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK.
- Elaboration check: every parameter ≥ 1, and H_TOTAL−1 and V_TOTAL−1 must fit in COORD_WIDTH. Violation is a fatal elaboration error.
- Internal counters: h in 0..H_TOTAL−1, v in 0..V_TOTAL−1.
- On an enabled edge:
  - h increments; at H_TOTAL−1 it wraps to 0.
  - v increments only on the h wrap; at V_TOTAL−1 with h wrapping, v also wraps to 0.
- All outputs are registers. On each enabled edge they load the decode of the pre-advance (h, v), so outputs lag the counters by one enabled cycle.
  - data_enable = (h < H_ACTIVE) & (v < V_ACTIVE)
  - hs_act = H_ACTIVE+H_FRONT ≤ h < H_ACTIVE+H_FRONT+H_SYNC
  - vs_act = V_ACTIVE+V_FRONT ≤ v < V_ACTIVE+V_FRONT+V_SYNC
  - vsync changes only with v, i.e. at line boundaries, aligned to h = 0.
  - hsync = hs_act ? H_SYNC_POL : ~H_SYNC_POL; vsync likewise with vs_act and V_SYNC_POL.
  - control = {vsync, hsync}.
  - x = h, y = v (raw counter values, also valid in blanking).
  - line_start = (h == 0); frame_start = (h == 0) & (v == 0).
- enable low: counters and all outputs hold their values. Strobes are not re-issued, so a held `frame_start` is seen by consumers only on enabled cycles.
- Reset has priority over enable. On the next edge:
  - h = v = 0, data_enable = 0
  - hsync = ~H_SYNC_POL, vsync = ~V_SYNC_POL, control = {vsync, hsync}
  - x = y = 0, line_start = 0, frame_start = 0
- Reset asserted mid-frame aborts the frame with no partial completion. The first enabled edge after reset release outputs the decode of (0,0): data_enable = 1, line_start = 1, frame_start = 1.
- No combinational path from any input to any output.

Test Plan:
- Reset then 3 enabled cycles, default params -> outputs x,y = 0,0 (data_enable = 1, frame_start = 1, line_start = 1), then x,y = 1,0 (strobes 0), then x,y = 2,0. `hsync` and `vsync` stay 1 throughout.
- Small params (H 4/1/2/1, V 3/1/1/1, H_TOTAL = 8, V_TOTAL = 6), enable always high, 48 cycles:
  - data_enable high exactly 12 cycles
  - hsync low at x = 5,6 of every line
  - vsync low for all 8 cycles of y = 4
  - frame_start pulses at cycle 1 and cycle 49
- Same small params, enable toggled 1-0-1-0 -> counters and outputs advance only on enabled edges. After 96 edges (48 enabled), state equals the 48-enabled-cycle run above.
- Default params, full frame of 420000 enabled cycles:
  - frame_start spacing = 420000
  - line_start count = 525
  - data_enable count = 307200
  - hsync low for x = 656..751
  - vsync low for y = 490..491
- Reset asserted at x = 300, y = 200 for 1 cycle -> next edge: all outputs at reset values. First enabled edge after release gives x = 0, y = 0, frame_start = 1.
- H_SYNC_POL = 1, V_SYNC_POL = 1 -> idle sync level 0, asserted 1. `control` equals {vsync, hsync} on every cycle (checked by assertion).
